spi_cmd_decoder: RTL and testbench
==================================

Name: spi_cmd_decoder

Overview:
- Sits directly downstream of the SPI slave.
- Consumes each completed 16-bit SPI frame (parallel word plus done strobe) and decodes it as a read or write command.
- Executes the command on a simple req/ack register bus toward the CNN control/weight registers.
- Loads a response word that the SPI slave shifts out during the next frame (full-duplex, one-frame response lag).

Parameters:
- DWIDTH, 16, SPI frame width; fixed frame format below; only 16 supported.
- AWIDTH, 7, register bus address width; equals frame address field width.
- TO_CYCLES, 256, bus timeout in clk cycles; only used with BUS_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  DWIDTH  frame received from SPI slave; valid when rx_valid=1.
- rx_valid  in  1  one-cycle strobe, frame complete (SPI slave done).
- tx_data  out  DWIDTH  response word, fed to SPI slave parallel input; held stable between updates.
- bus_req  out  1  register bus request; held until bus_ack.
- bus_we  out  1  1=write, 0=read; stable while bus_req=1.
- bus_addr  out  AWIDTH  register address; stable while bus_req=1.
- bus_wdata  out  8  write data; stable while bus_req=1.
- bus_ack  in  1  one-cycle completion strobe; sampled only while bus_req=1.
- bus_rdata  in  8  read data; valid with bus_ack on reads.
- busy  out  1  1 while FSM is not IDLE.
- overflow  out  1  sticky: frame arrived while busy and was dropped.
- err  out  1  sticky: bus timeout (BUS_TIMEOUT_EN only; else constant 0).

Behaviour:
- Frame format: [15] RW (1=write), [14:8] addr, [7:0] data (write data; ignored on read).
- Reset values: tx_data=16'h0000, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, busy=0, overflow=0, err=0, FSM=IDLE, timeout counter=0.
- FSM states: IDLE, ISSUE.
- IDLE + rx_valid, addr != 7'h7F:
  - Register bus_we/bus_addr/bus_wdata from rx_data.
  - bus_req=1 and busy=1 from the next cycle.
  - Go to ISSUE.
- IDLE + rx_valid, addr == 7'h7F (local status register, no bus cycle; stay IDLE, no busy):
  - Read: tx_data <= {1'b0,7'h7F,6'b0,overflow,err} next edge, using pre-update flag values.
  - Write: if data[0]=1, clear overflow and err; tx_data <= {1'b1,7'h7F,data}.
- ISSUE + bus_ack:
  - Next edge: bus_req=0, FSM=IDLE, busy=0.
  - Write: tx_data <= {1'b1,addr,wdata}.
  - Read: tx_data <= {1'b0,addr,bus_rdata}.
- Latency: rx_valid at cycle N -> bus_req high at N+1. bus_ack at cycle M -> tx_data updated and bus_req low at M+1. Minimum rx_valid-to-tx_data is 2 cycles when bus_ack is asserted in cycle N+1.
- rx_valid while in ISSUE: frame dropped, overflow <= 1. This includes the same cycle as bus_ack; the FSM accepts frames only in IDLE.
- Flag clear vs set in the same cycle: set wins. Clearing also requires an IDLE-state frame, so it cannot coincide with a drop.
- bus_ack while bus_req=0: ignored.
- tx_data changes only on the edges listed above; otherwise it holds.
- Reset asserted mid-transaction: immediate return to reset values. The pending bus cycle is abandoned (bus_req drops asynchronously).

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - Counter clears on entering ISSUE and increments each ISSUE cycle without bus_ack.
  - When the count reaches TO_CYCLES-1 without bus_ack: next edge bus_req=0, FSM=IDLE, err<=1, tx_data<=16'hDEAD.
  - bus_ack on that same final cycle wins: normal completion, no error.
- Not defined: no counter; ISSUE waits indefinitely for bus_ack; err tied to 0.

Test Plan:
- Write: rx_data=16'h8A3C pulse -> next cycle bus_req=1, bus_we=1, bus_addr=7'h0A, bus_wdata=8'h3C; bus_ack 3 cycles later -> tx_data=16'h8A3C, bus_req=0, busy=0.
- Read: rx_data=16'h0500, bus_ack with bus_rdata=8'h5A -> bus_we=0, bus_addr=7'h05, tx_data=16'h055A one cycle after ack.
- Overflow: second rx_valid (16'h8101) while in ISSUE -> no second bus cycle, overflow=1. Then rx_data=16'h7F00 -> tx_data=16'h7F02, no bus_req. Then rx_data=16'hFF01 -> overflow=0, tx_data=16'hFF01.
- Simultaneous: rx_valid and bus_ack in the same ISSUE cycle -> first transaction completes, new frame dropped, overflow=1.
- Timeout (BUS_TIMEOUT_EN, TO_CYCLES=8): read with no bus_ack -> bus_req drops after 8 cycles, err=1, tx_data=16'hDEAD. Without the macro, bus_req stays high for 1000 cycles.
- Reset mid-ISSUE: rst pulse while bus_req=1 -> bus_req=0, busy=0, tx_data=16'h0000 immediately. Next frame is processed normally.

Source files
------------

// File: rtl/spi_cmd_decoder_if.sv
// Signal bundle between spi_cmd_decoder and its environment (SPI slave side and register bus).
// master: decoder view; slave: SPI slave / register bus / testbench view.
interface spi_cmd_decoder_if #(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned AWIDTH = 7
);
  logic [DWIDTH-1:0] rx_data;
  logic              rx_valid;
  logic [DWIDTH-1:0] tx_data;
  logic              bus_req;
  logic              bus_we;
  logic [AWIDTH-1:0] bus_addr;
  logic [7:0]        bus_wdata;
  logic              bus_ack;
  logic [7:0]        bus_rdata;
  logic              busy;
  logic              overflow;
  logic              err;

  modport master (
    input  rx_data, rx_valid, bus_ack, bus_rdata,
    output tx_data, bus_req, bus_we, bus_addr, bus_wdata, busy, overflow, err
  );

  modport slave (
    output rx_data, rx_valid, bus_ack, bus_rdata,
    input  tx_data, bus_req, bus_we, bus_addr, bus_wdata, busy, overflow, err
  );
endinterface

// File: rtl/spi_cmd_decoder.sv
// Decodes 16-bit SPI frames ({RW, addr[6:0], data[7:0]}) into req/ack register bus cycles
// and loads a response word for the next frame. Optional bus timeout: define BUS_TIMEOUT_EN.
module spi_cmd_decoder #(
  parameter int unsigned DWIDTH    = 16,
  parameter int unsigned AWIDTH    = 7,
  parameter int unsigned TO_CYCLES = 256
) (
  input  logic             clk,
  input  logic             rst,
  spi_cmd_decoder_if.master sif
);

  typedef enum logic {IDLE, ISSUE} state_t;

  localparam logic [AWIDTH-1:0] STATUS_ADDR = '1;

  state_t            state_q, state_d;
  logic [DWIDTH-1:0] tx_q, tx_d;
  logic              we_q, we_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              ovf_q, ovf_d;

  logic              rx_rw;
  logic [AWIDTH-1:0] rx_addr;
  logic [7:0]        rx_dat;

  assign rx_rw   = sif.rx_data[15];
  assign rx_addr = sif.rx_data[14:8];
  assign rx_dat  = sif.rx_data[7:0];

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned CW = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TO_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tx_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ovf_q   <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ovf_q   <= ovf_d;
`ifdef BUS_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ovf_d   = ovf_q;
`ifdef BUS_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (sif.rx_valid) begin
          if (rx_addr == STATUS_ADDR) begin
            if (rx_rw) begin
              tx_d = {1'b1, STATUS_ADDR, rx_dat};
              if (rx_dat[0]) begin
                ovf_d = 1'b0;
`ifdef BUS_TIMEOUT_EN
                err_d = 1'b0;
`endif
              end
            end else begin
`ifdef BUS_TIMEOUT_EN
              tx_d = {1'b0, STATUS_ADDR, 6'b0, ovf_q, err_q};
`else
              tx_d = {1'b0, STATUS_ADDR, 6'b0, ovf_q, 1'b0};
`endif
            end
          end else begin
            we_d    = rx_rw;
            addr_d  = rx_addr;
            wdata_d = rx_dat;
            state_d = ISSUE;
`ifdef BUS_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      ISSUE: begin
        // Frames are only accepted in IDLE, including the cycle bus_ack arrives.
        if (sif.rx_valid) ovf_d = 1'b1;
        if (sif.bus_ack) begin
          state_d = IDLE;
          tx_d    = we_q ? {1'b1, addr_q, wdata_q} : {1'b0, addr_q, sif.bus_rdata};
        end
`ifdef BUS_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
          tx_d    = 16'hDEAD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign sif.tx_data   = tx_q;
  assign sif.bus_req   = (state_q == ISSUE);
  assign sif.busy      = (state_q != IDLE);
  assign sif.bus_we    = we_q;
  assign sif.bus_addr  = addr_q;
  assign sif.bus_wdata = wdata_q;
  assign sif.overflow  = ovf_q;
`ifdef BUS_TIMEOUT_EN
  assign sif.err       = err_q;
`else
  assign sif.err       = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed self-checking bench for spi_cmd_decoder; timeout scenario follows BUS_TIMEOUT_EN.
module tb_spi_cmd_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  spi_cmd_decoder_if #(.DWIDTH(16), .AWIDTH(7)) sif ();

  spi_cmd_decoder #(.DWIDTH(16), .AWIDTH(7), .TO_CYCLES(8)) dut (
    .clk (clk),
    .rst (rst),
    .sif (sif.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d);
    sif.rx_data  = d;
    sif.rx_valid = 1'b1;
    tick();
    sif.rx_valid = 1'b0;
  endtask

  task automatic ack(input logic [7:0] rd);
    sif.bus_rdata = rd;
    sif.bus_ack   = 1'b1;
    tick();
    sif.bus_ack   = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({sif.tx_data, sif.bus_req, sif.bus_we, sif.bus_addr, sif.bus_wdata, sif.busy, sif.overflow, sif.err} !== 37'd0) begin
      errors++;
      $display("FAIL reset_state: got tx=%h req=%b we=%b addr=%h wd=%h busy=%b ovf=%b err=%b, want all zero",
               sif.tx_data, sif.bus_req, sif.bus_we, sif.bus_addr, sif.bus_wdata, sif.busy, sif.overflow, sif.err);
    end
  endtask

  task automatic test_write();
    send(16'h8A3C);
    checks++;
    if ({sif.bus_req, sif.bus_we, sif.bus_addr, sif.bus_wdata, sif.busy} !== {1'b1, 1'b1, 7'h0A, 8'h3C, 1'b1}) begin
      errors++;
      $display("FAIL write_issue: got req=%b we=%b addr=%h wd=%h busy=%b, want 1 1 0a 3c 1",
               sif.bus_req, sif.bus_we, sif.bus_addr, sif.bus_wdata, sif.busy);
    end
    tick();
    tick();
    checks++;
    if (sif.bus_req !== 1'b1 || sif.tx_data !== 16'h0000) begin
      errors++;
      $display("FAIL write_hold: got req=%b tx=%h, want 1 0000", sif.bus_req, sif.tx_data);
    end
    ack(8'hFF);
    checks++;
    if ({sif.tx_data, sif.bus_req, sif.busy} !== {16'h8A3C, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL write_done: got tx=%h req=%b busy=%b, want 8a3c 0 0", sif.tx_data, sif.bus_req, sif.busy);
    end
  endtask

  task automatic test_read();
    send(16'h0500);
    checks++;
    if ({sif.bus_req, sif.bus_we, sif.bus_addr} !== {1'b1, 1'b0, 7'h05}) begin
      errors++;
      $display("FAIL read_issue: got req=%b we=%b addr=%h, want 1 0 05", sif.bus_req, sif.bus_we, sif.bus_addr);
    end
    ack(8'h5A);
    checks++;
    if ({sif.tx_data, sif.bus_req} !== {16'h055A, 1'b0}) begin
      errors++;
      $display("FAIL read_done: got tx=%h req=%b, want 055a 0", sif.tx_data, sif.bus_req);
    end
  endtask

  task automatic test_idle_ack();
    ack(8'h99);
    checks++;
    if ({sif.tx_data, sif.bus_req, sif.busy} !== {16'h055A, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL idle_ack: got tx=%h req=%b busy=%b, want 055a 0 0", sif.tx_data, sif.bus_req, sif.busy);
    end
  endtask

  task automatic test_overflow();
    send(16'h1234);
    send(16'h8101);
    checks++;
    if ({sif.overflow, sif.bus_req, sif.bus_we, sif.bus_addr} !== {1'b1, 1'b1, 1'b0, 7'h12}) begin
      errors++;
      $display("FAIL ovf_drop: got ovf=%b req=%b we=%b addr=%h, want 1 1 0 12",
               sif.overflow, sif.bus_req, sif.bus_we, sif.bus_addr);
    end
    ack(8'h77);
    tick();
    checks++;
    if ({sif.tx_data, sif.bus_req, sif.busy} !== {16'h1277, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL ovf_no_second: got tx=%h req=%b busy=%b, want 1277 0 0", sif.tx_data, sif.bus_req, sif.busy);
    end
    send(16'h7F00);
    checks++;
    if ({sif.tx_data, sif.bus_req, sif.busy} !== {16'h7F02, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL status_read: got tx=%h req=%b busy=%b, want 7f02 0 0", sif.tx_data, sif.bus_req, sif.busy);
    end
    send(16'hFF01);
    checks++;
    if ({sif.tx_data, sif.overflow, sif.bus_req} !== {16'hFF01, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL status_clear: got tx=%h ovf=%b req=%b, want ff01 0 0", sif.tx_data, sif.overflow, sif.bus_req);
    end
  endtask

  task automatic test_simultaneous();
    send(16'h8A55);
    sif.rx_data   = 16'h0203;
    sif.rx_valid  = 1'b1;
    sif.bus_ack   = 1'b1;
    sif.bus_rdata = 8'h11;
    tick();
    sif.rx_valid  = 1'b0;
    sif.bus_ack   = 1'b0;
    checks++;
    if ({sif.tx_data, sif.bus_req, sif.overflow} !== {16'h8A55, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL simul_done: got tx=%h req=%b ovf=%b, want 8a55 0 1", sif.tx_data, sif.bus_req, sif.overflow);
    end
    tick();
    checks++;
    if (sif.bus_req !== 1'b0 || sif.busy !== 1'b0) begin
      errors++;
      $display("FAIL simul_dropped: got req=%b busy=%b, want 0 0", sif.bus_req, sif.busy);
    end
    send(16'hFF01);
  endtask

  task automatic test_timeout();
    int n;
    send(16'h0300);
`ifdef BUS_TIMEOUT_EN
    n = 0;
    while (sif.bus_req === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    checks++;
    if (n != 8 || {sif.err, sif.tx_data, sif.busy} !== {1'b1, 16'hDEAD, 1'b0}) begin
      errors++;
      $display("FAIL timeout: got high_cycles=%0d err=%b tx=%h busy=%b, want 8 1 dead 0", n, sif.err, sif.tx_data, sif.busy);
    end
    send(16'hFF01);
    checks++;
    if (sif.err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got err=%b, want 0", sif.err);
    end
`else
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      if (sif.bus_req === 1'b1) n++;
      tick();
    end
    checks++;
    if (n != 1000 || sif.err !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout: got high_cycles=%0d err=%b, want 1000 0", n, sif.err);
    end
    ack(8'h42);
    checks++;
    if ({sif.tx_data, sif.bus_req} !== {16'h0342, 1'b0}) begin
      errors++;
      $display("FAIL late_ack: got tx=%h req=%b, want 0342 0", sif.tx_data, sif.bus_req);
    end
`endif
  endtask

  task automatic test_reset_mid();
    send(16'h0400);
    rst = 1'b1;
    #1;
    checks++;
    if ({sif.bus_req, sif.busy, sif.tx_data} !== {1'b0, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL reset_mid: got req=%b busy=%b tx=%h, want 0 0 0000", sif.bus_req, sif.busy, sif.tx_data);
    end
    #2;
    rst = 1'b0;
    tick();
    send(16'h8B11);
    ack(8'h00);
    checks++;
    if ({sif.tx_data, sif.bus_req} !== {16'h8B11, 1'b0}) begin
      errors++;
      $display("FAIL after_reset: got tx=%h req=%b, want 8b11 0", sif.tx_data, sif.bus_req);
    end
  endtask

  initial begin
    sif.rx_data   = '0;
    sif.rx_valid  = 1'b0;
    sif.bus_ack   = 1'b0;
    sif.bus_rdata = '0;
    tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_write();
    test_read();
    test_idle_ack();
    test_overflow();
    test_simultaneous();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
